// File: rtl/alu_result_writeback_if.sv
// Shared RV32I enums and the bundle between the control/ALU side and the
// writeback block (memory port, register-file write port, PC output).
package rv32i_pkg;
  typedef enum logic [2:0] {
    FETCH_S1,
    DECODE_S2,
    EXECUTE_S3,
    MEMORY_S4,
    WRITEBACK_S5
  } RV32I_CONTROL_UNIT_FSM_t;

  typedef enum logic [6:0] {
    R_TYPE      = 7'b0110011,
    I_TYPE      = 7'b0010011,
    I_LOAD_TYPE = 7'b0000011,
    S_TYPE      = 7'b0100011,
    B_TYPE      = 7'b1100011,
    J_TYPE      = 7'b1101111,
    I_JALR_TYPE = 7'b1100111,
    U_LUI_TYPE  = 7'b0110111,
    U_AUI_TYPE  = 7'b0010111
  } RV32I_OPCODE_t;
endpackage

interface alu_result_writeback_if
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) ();
  RV32I_CONTROL_UNIT_FSM_t control_unit_state;
  RV32I_OPCODE_t           opcode;
  logic [2:0]              funct3;
  logic [4:0]              rd_addr;
  logic                    branch_cond;
  logic [XLEN-1:0]         alu_result;
  logic [XLEN-1:0]         rs2;
  logic [XLEN-1:0]         mem_rdata;
  logic [XLEN-1:0]         program_counter;
  logic [XLEN-1:0]         mem_addr;
  logic [XLEN-1:0]         mem_wdata;
  logic [3:0]              mem_be;
  logic                    mem_we;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic                    misaligned_err;

  // Control unit / ALU / memory side
  modport master (
    output control_unit_state, opcode, funct3, rd_addr, branch_cond,
           alu_result, rs2, mem_rdata,
    input  program_counter, mem_addr, mem_wdata, mem_be, mem_we,
           rf_we, rf_waddr, rf_wdata, misaligned_err
  );

  // Writeback block side
  modport slave (
    input  control_unit_state, opcode, funct3, rd_addr, branch_cond,
           alu_result, rs2, mem_rdata,
    output program_counter, mem_addr, mem_wdata, mem_be, mem_we,
           rf_we, rf_waddr, rf_wdata, misaligned_err
  );
endinterface

// File: rtl/alu_result_writeback.sv
// ALU return path of the multi-cycle RV32I core: captures the ALU result in
// each control-unit state, owns the PC, aligns load/store data and drives the
// register-file write port.
module alu_result_writeback
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  alu_result_writeback_if.slave        bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] seq_pc_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] alu_out_q;
  logic [XLEN-1:0] load_q;
  logic            taken_q;
  logic            err_q;
  // Set once the instruction has executed; a reset in mid-flight clears it so
  // nothing from the aborted instruction can reach memory, rd or the PC.
  logic            vld_q;
  // Misalignment of the current memory access, used to veto the writeback.
  logic            mis_q;

  logic [1:0]      byte_off;
  logic            is_load;
  logic            is_store;
  logic            mis_access;
  logic            writes_rd;

  // Pick the addressed byte/half/word out of the read word and extend it.
  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] word,
                                                 input logic [1:0] off,
                                                 input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_align = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_align = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_align = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_align = {{(XLEN-16){1'b0}}, h};
      default: load_align = word;
    endcase
  endfunction

  // Halves need an even address, words a 4-byte aligned one; bytes never trap.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  assign byte_off   = alu_out_q[1:0];
  assign is_load    = (bus.opcode == I_LOAD_TYPE);
  assign is_store   = (bus.opcode == S_TYPE);
  assign mis_access = misaligned(bus.funct3, byte_off);

  assign bus.program_counter = pc_q;
  assign bus.mem_addr        = {alu_out_q[XLEN-1:2], 2'b00};
  assign bus.misaligned_err  = err_q;
  assign bus.rf_waddr        = bus.rd_addr;

  // Per-state captures of the ALU result, load data, branch decision and PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      seq_pc_q  <= '0;
      target_q  <= '0;
      alu_out_q <= '0;
      load_q    <= '0;
      taken_q   <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      case (bus.control_unit_state)
        FETCH_S1:  seq_pc_q <= bus.alu_result;
        DECODE_S2: target_q <= bus.alu_result;
        EXECUTE_S3: begin
          alu_out_q <= bus.alu_result;
          vld_q     <= 1'b1;
          mis_q     <= 1'b0;
          if (bus.opcode == B_TYPE)
            taken_q <= bus.branch_cond;
          else
            taken_q <= (bus.opcode == J_TYPE) || (bus.opcode == I_JALR_TYPE);
        end
        MEMORY_S4: begin
          if (vld_q && (is_load || is_store)) begin
            mis_q <= mis_access;
            if (mis_access)
              err_q <= 1'b1;
          end
          if (vld_q && is_load)
            load_q <= load_align(bus.mem_rdata, byte_off, bus.funct3);
        end
        WRITEBACK_S5: begin
          if (vld_q) begin
            if (bus.opcode == I_JALR_TYPE)
              pc_q <= {alu_out_q[XLEN-1:1], 1'b0};
            else if (taken_q)
              pc_q <= target_q;
            else
              pc_q <= seq_pc_q;
          end
          vld_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Store lane steering and write strobe, live only in the memory state.
  always_comb begin
    bus.mem_be    = 4'b0000;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (vld_q && is_store && bus.control_unit_state == MEMORY_S4) begin
      case (bus.funct3)
        3'b000: begin
          bus.mem_be    = 4'b0001 << byte_off;
          bus.mem_wdata = {4{bus.rs2[7:0]}};
        end
        3'b001: begin
          bus.mem_be    = 4'b0011 << byte_off;
          bus.mem_wdata = {2{bus.rs2[15:0]}};
        end
        3'b010: begin
          bus.mem_be    = 4'b1111;
          bus.mem_wdata = bus.rs2;
        end
        default: ;
      endcase
      bus.mem_we = (bus.mem_be != 4'b0000) && !mis_access;
    end
  end

  // Register-file write strobe and writeback data selection.
  always_comb begin
    case (bus.opcode)
      R_TYPE, I_TYPE, I_LOAD_TYPE, U_LUI_TYPE,
      U_AUI_TYPE, J_TYPE, I_JALR_TYPE: writes_rd = 1'b1;
      default:                         writes_rd = 1'b0;
    endcase
    bus.rf_we = vld_q && writes_rd && (bus.control_unit_state == WRITEBACK_S5) &&
                (bus.rd_addr != 5'd0) && !(is_load && mis_q);
    if (is_load)
      bus.rf_wdata = load_q;
    else if (bus.opcode == J_TYPE || bus.opcode == I_JALR_TYPE)
      bus.rf_wdata = seq_pc_q;
    else
      bus.rf_wdata = alu_out_q;
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: walks each instruction through the
// five control-unit states and compares strobes, data and PC with a table.
module tb_alu_result_writeback;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alu_result_writeback_if #(.XLEN(32)) bus ();

  alu_result_writeback #(.XLEN(32), .RESET_PC(32'h0040_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    RV32I_OPCODE_t op;
    logic [2:0]    f3;
    logic [4:0]    rd;
    logic [31:0]   pc4;
    logic [31:0]   tgt;
    logic [31:0]   alu;
    logic          bc;
    logic [31:0]   rs2;
    logic [31:0]   rdata;
    logic          e_rf_we;
    logic [31:0]   e_rf_wdata;
    logic [31:0]   e_pc;
    logic          e_mem_we;
    logic [3:0]    e_be;
    logic [31:0]   e_mwdata;
    logic          e_err;
  } vec_t;

  vec_t vq[$];

  function automatic void add(RV32I_OPCODE_t op, logic [2:0] f3, logic [4:0] rd,
                              logic [31:0] pc4, logic [31:0] tgt, logic [31:0] alu,
                              logic bc, logic [31:0] rs2, logic [31:0] rdata,
                              logic e_rf_we, logic [31:0] e_rf_wdata, logic [31:0] e_pc,
                              logic e_mem_we, logic [3:0] e_be, logic [31:0] e_mwdata,
                              logic e_err);
    vec_t v;
    v.op = op; v.f3 = f3; v.rd = rd; v.pc4 = pc4; v.tgt = tgt; v.alu = alu;
    v.bc = bc; v.rs2 = rs2; v.rdata = rdata; v.e_rf_we = e_rf_we;
    v.e_rf_wdata = e_rf_wdata; v.e_pc = e_pc; v.e_mem_we = e_mem_we;
    v.e_be = e_be; v.e_mwdata = e_mwdata; v.e_err = e_err;
    vq.push_back(v);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic drive(RV32I_CONTROL_UNIT_FSM_t st, logic [31:0] alu);
    bus.control_unit_state = st;
    bus.alu_result         = alu;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prev_pc;

  initial begin
    bus.control_unit_state = FETCH_S1;
    bus.opcode      = R_TYPE;
    bus.funct3      = 3'b000;
    bus.rd_addr     = 5'd0;
    bus.branch_cond = 1'b0;
    bus.alu_result  = '0;
    bus.rs2         = '0;
    bus.mem_rdata   = '0;

    //  op           f3  rd  pc4           tgt           alu           bc  rs2           rdata          we wdata         pc            mwe be     mwdata        err
    add(R_TYPE,      0,  5, 32'h0040_0004, 32'h0040_0100, 32'h0000_0007, 0, 32'h0,        32'h0,         1, 32'h0000_0007, 32'h0040_0004, 0, 4'h0, 32'h0,        0);
    add(I_LOAD_TYPE, 0,  6, 32'h0040_0008, 32'h0,         32'h1001_0003, 0, 32'h0,        32'h80FF_FFFF, 1, 32'hFFFF_FF80, 32'h0040_0008, 0, 4'h0, 32'h0,        0);
    add(I_LOAD_TYPE, 4,  7, 32'h0040_000C, 32'h0,         32'h1001_0003, 0, 32'h0,        32'h80FF_FFFF, 1, 32'h0000_0080, 32'h0040_000C, 0, 4'h0, 32'h0,        0);
    add(S_TYPE,      1,  9, 32'h0040_0010, 32'h0,         32'h1001_0002, 0, 32'h1234_ABCD, 32'h0,        0, 32'h0,         32'h0040_0010, 1, 4'hC, 32'hABCD_ABCD, 0);
    add(B_TYPE,      0,  0, 32'h0040_0014, 32'h0040_0020, 32'h0,         1, 32'h0,        32'h0,         0, 32'h0,         32'h0040_0020, 0, 4'h0, 32'h0,        0);
    add(B_TYPE,      0,  0, 32'h0040_0024, 32'h0040_0040, 32'h0,         0, 32'h0,        32'h0,         0, 32'h0,         32'h0040_0024, 0, 4'h0, 32'h0,        0);
    add(I_JALR_TYPE, 0,  0, 32'h0040_0028, 32'h0,         32'h0040_0105, 0, 32'h0,        32'h0,         0, 32'h0,         32'h0040_0104, 0, 4'h0, 32'h0,        0);
    add(J_TYPE,      0,  1, 32'h0040_0108, 32'h0040_0200, 32'h0,         0, 32'h0,        32'h0,         1, 32'h0040_0108, 32'h0040_0200, 0, 4'h0, 32'h0,        0);
    add(U_LUI_TYPE,  0,  0, 32'h0040_0204, 32'h0,         32'hABCD_E000, 0, 32'h0,        32'h0,         0, 32'h0,         32'h0040_0204, 0, 4'h0, 32'h0,        0);
    add(I_LOAD_TYPE, 1, 10, 32'h0040_0208, 32'h0,         32'h1001_0002, 0, 32'h0,        32'h8001_1234, 1, 32'hFFFF_8001, 32'h0040_0208, 0, 4'h0, 32'h0,        0);
    add(S_TYPE,      2,  0, 32'h0040_020C, 32'h0,         32'h1001_0004, 0, 32'hDEAD_BEEF, 32'h0,        0, 32'h0,         32'h0040_020C, 1, 4'hF, 32'hDEAD_BEEF, 0);
    add(RV32I_OPCODE_t'(7'h7F), 0, 3, 32'h0040_0210, 32'h0, 32'h0000_0055, 0, 32'h0,  32'h0,         0, 32'h0,         32'h0040_0210, 0, 4'h0, 32'h0,        0);
    add(I_TYPE,      0,  4, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 0, 32'h0,        32'h0,         1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 4'h0, 32'h0,        0);
    add(I_LOAD_TYPE, 2,  8, 32'h0000_0004, 32'h0,         32'h1001_0002, 0, 32'h0,        32'h1234_5678, 0, 32'h0,         32'h0000_0004, 0, 4'h0, 32'h0,        1);
    add(S_TYPE,      2,  0, 32'h0000_0008, 32'h0,         32'h1001_0001, 0, 32'h1122_3344, 32'h0,        0, 32'h0,         32'h0000_0008, 0, 4'hF, 32'h1122_3344, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset pc", bus.program_counter, 32'h0040_0000);
    chk("reset rf_we", {31'b0, bus.rf_we}, 32'h0);
    chk("reset mem_be", {28'b0, bus.mem_be}, 32'h0);
    chk("reset misaligned_err", {31'b0, bus.misaligned_err}, 32'h0);
    adv();

    // Reset during EXECUTE_S3 of an ADD: the aborted instruction must not write
    bus.opcode = R_TYPE; bus.rd_addr = 5'd5;
    drive(FETCH_S1, 32'h0040_0004);   adv();
    drive(DECODE_S2, 32'h0040_0100);  adv();
    drive(EXECUTE_S3, 32'h0000_0007);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    drive(WRITEBACK_S5, 32'h0);
    chk("midreset rf_we", {31'b0, bus.rf_we}, 32'h0);
    adv();
    chk("midreset pc", bus.program_counter, 32'h0040_0000);

    // Table-driven instruction sequence
    prev_pc = 32'h0040_0000;
    for (int i = 0; i < vq.size(); i++) begin
      bus.opcode      = vq[i].op;
      bus.funct3      = vq[i].f3;
      bus.rd_addr     = vq[i].rd;
      bus.branch_cond = vq[i].bc;
      bus.rs2         = vq[i].rs2;
      bus.mem_rdata   = vq[i].rdata;
      drive(FETCH_S1, vq[i].pc4);    adv();
      drive(DECODE_S2, vq[i].tgt);   adv();
      drive(EXECUTE_S3, vq[i].alu);  adv();
      drive(MEMORY_S4, 32'h0);
      chk($sformatf("v%0d mem_be", i), {28'b0, bus.mem_be}, {28'b0, vq[i].e_be});
      chk($sformatf("v%0d mem_we", i), {31'b0, bus.mem_we}, {31'b0, vq[i].e_mem_we});
      chk($sformatf("v%0d mem4 rf_we", i), {31'b0, bus.rf_we}, 32'h0);
      chk($sformatf("v%0d pc hold", i), bus.program_counter, prev_pc);
      if (vq[i].op == S_TYPE) begin
        chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vq[i].e_mwdata);
        chk($sformatf("v%0d mem_addr", i), bus.mem_addr, {vq[i].alu[31:2], 2'b00});
      end
      adv();
      drive(WRITEBACK_S5, 32'h0);
      chk($sformatf("v%0d rf_we", i), {31'b0, bus.rf_we}, {31'b0, vq[i].e_rf_we});
      chk($sformatf("v%0d wb mem_be", i), {28'b0, bus.mem_be}, 32'h0);
      if (vq[i].e_rf_we) begin
        chk($sformatf("v%0d rf_waddr", i), {27'b0, bus.rf_waddr}, {27'b0, vq[i].rd});
        chk($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vq[i].e_rf_wdata);
      end
      adv();
      chk($sformatf("v%0d pc", i), bus.program_counter, vq[i].e_pc);
      chk($sformatf("v%0d misaligned_err", i), {31'b0, bus.misaligned_err}, {31'b0, vq[i].e_err});
      drive(FETCH_S1, 32'h0);
      chk($sformatf("v%0d rf_we pulse end", i), {31'b0, bus.rf_we}, 32'h0);
      prev_pc = vq[i].e_pc;
    end

    // Only reset clears the sticky flag and restores the PC
    rst = 1'b1;
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("final reset misaligned_err", {31'b0, bus.misaligned_err}, 32'h0);
    chk("final reset pc", bus.program_counter, 32'h0040_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Return path of the ALU in the multi-cycle RV32I core. It captures `alu_result` in each control-unit state and owns the architectural PC register.
- It aligns load data and store data/byte enables, and selects the value written to rd and the next PC.
- Sits between the ALU/data memory and the register file/PC, driven by the same `control_unit_state` and opcode that steer the ALU inputs.

Parameters:
- XLEN, 32, operand width.
- RESET_PC, 32'h0040_0000, PC value after reset.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high
- control_unit_state  input  RV32I_CONTROL_UNIT_FSM_t  current FSM state; FETCH_S1, DECODE_S2, EXECUTE_S3, MEMORY_S4, WRITEBACK_S5
- opcode  input  RV32I_OPCODE_t  decoded opcode of current instruction
- funct3  input  3  load/store width and signedness
- rd_addr  input  5  destination register index
- branch_cond  input  1  comparator result for B_TYPE, valid in EXECUTE_S3
- alu_result  input  XLEN  ALU output
- rs2  input  XLEN  store source data
- mem_rdata  input  XLEN  data memory read word, valid in MEMORY_S4
- program_counter  output  XLEN  architectural PC, registered
- mem_addr  output  XLEN  data address: `alu_out_q` with bits [1:0] forced to 0
- mem_wdata  output  XLEN  store data shifted to byte lane
- mem_be  output  4  store byte enables; 0 outside MEMORY_S4
- mem_we  output  1  store strobe
- rf_we  output  1  register-file write strobe
- rf_waddr  output  5  rd index
- rf_wdata  output  XLEN  writeback data
- misaligned_err  output  1  sticky misaligned-access flag

Behaviour:
- Reset (rst high at a clk edge):
  - `program_counter` = RESET_PC.
  - `seq_pc_q`, `target_q`, `alu_out_q`, `load_q` = 0.
  - `taken_q` = 0; `misaligned_err` = 0.
  - All strobes and `mem_be` low.
  - Reset mid-instruction discards every captured value; no write occurs.
- FETCH_S1: `seq_pc_q` <= `alu_result` (PC+4).
- DECODE_S2: `target_q` <= `alu_result` (PC+imm, speculative).
- EXECUTE_S3:
  - `alu_out_q` <= `alu_result`.
  - `taken_q` <= `branch_cond` when opcode is B_TYPE, else 1 for J_TYPE/I_JALR_TYPE, else 0.
- MEMORY_S4, combinational strobes valid only in this state:
  - S_TYPE, funct3 000 (SB): `mem_be` = 0001 << addr[1:0]; `mem_wdata` = {4{rs2[7:0]}}.
  - S_TYPE, 001 (SH): `mem_be` = 0011 << addr[1:0]; `mem_wdata` = {2{rs2[15:0]}}.
  - S_TYPE, 010 (SW): `mem_be` = 1111; `mem_wdata` = rs2.
  - `mem_we` = 1 for S_TYPE when aligned.
  - I_LOAD_TYPE: `load_q` <= selected byte/half/word, sign-extended for funct3 000/001/010 and zero-extended for 100/101.
- Misalignment:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0.
  - Suppresses `mem_we` and the following `rf_we`, and sets `misaligned_err`.
  - `misaligned_err` holds until rst.
- WRITEBACK_S5:
  - `rf_we` pulses exactly one cycle for R, I, I_LOAD, U_LUI, U_AUI, J, I_JALR, and only when rd_addr ≠ 0.
  - `rf_wdata` selection:
    - `load_q` for I_LOAD.
    - `seq_pc_q` for J/I_JALR.
    - `alu_out_q` otherwise.
  - PC update, on the same edge:
    - I_JALR → {alu_out_q[XLEN-1:1], 1'b0}.
    - J or taken B → `target_q`.
    - Otherwise → `seq_pc_q`.
- State gating:
  - `program_counter` changes only at the end of WRITEBACK_S5 or on reset.
  - Captures occur only in their own state; other states hold.
  - Unknown opcode: no rf/mem write; PC advances to `seq_pc_q`.
- Arithmetic: all registers are XLEN wide; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

Test Plan:
- Reset → `program_counter`=32'h0040_0000, `rf_we`=0, `mem_be`=0; assert rst during EXECUTE_S3 of an ADD → no `rf_we`, PC=RESET_PC.
- ADD x5 with alu_result=0x0000_0007 in S3 → S5: `rf_we`=1 for one cycle, `rf_waddr`=5, `rf_wdata`=7, PC=0x0040_0004.
- LB with addr=0x1001_0003, mem_rdata=0x80FF_FFFF → `rf_wdata`=0xFFFF_FF80; same with LBU → 0x0000_0080.
- SH with addr=0x1001_0002, rs2=0x1234_ABCD → `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1; LW at 0x1001_0002 → `misaligned_err`=1, no `rf_we`.
- BEQ with target 0x0040_0020: branch_cond=1 → PC=0x0040_0020; branch_cond=0 → PC=seq 0x0040_0004, no `rf_we`.
- JALR x0, alu_result=0x0040_0105 → PC=0x0040_0104, `rf_we`=0; JAL x1 → `rf_wdata`=PC+4, PC=`target_q`.
